// File: rtl/mrv32_mem_stage.sv
// Memory-stage controller: effective-address generation, LSU request hold, writeback and retire pulses.
// Optional LSU timeout abort is compiled in with `define MRV32_MEM_TIMEOUT_EN.

package mrv32_pkg;
  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;
endpackage

module mrv32_mem_stage
  import mrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  output logic        mem_valid,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [3:0]  mem_wstrb,
  output logic [2:0]  load_funct3,
  output logic [31:0] eff_addr,
  output logic [31:0] store_data,
  input  logic        lsu_done,
  input  logic [31:0] load_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        op_done,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  // Legal width plus natural alignment; illegal funct3 encodings fold into the misaligned path.
  function automatic logic aligned_f(input logic ld, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    logic ok;
    legal = ld ? ((f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111)) : (f3 < 3'b011);
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return legal & ok;
  endfunction

  function automatic logic [3:0] wstrb_f(input logic [1:0] sz);
    case (sz)
      2'b00:   return WSTRB_B;
      2'b01:   return WSTRB_H;
      2'b10:   return WSTRB_W;
      default: return WSTRB_NONE;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic        in_ready_d, mem_valid_d, mem_ren_d, mem_wen_d;
  logic [3:0]  mem_wstrb_d;
  logic [2:0]  load_funct3_d;
  logic [31:0] eff_addr_d, store_data_d, wb_data_d;
  logic [4:0]  wb_rd_d;
  logic        wb_valid_d, op_done_d, err_misalign_d, err_timeout_d;

  logic [31:0] addr_c;
  logic        ld_c;
  assign addr_c = in_rs1 + in_imm;
  assign ld_c   = in_is_load;

`ifdef MRV32_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_d        = state_q;
    is_load_d      = is_load_q;
    in_ready_d     = in_ready;
    mem_valid_d    = mem_valid;
    mem_ren_d      = mem_ren;
    mem_wen_d      = mem_wen;
    mem_wstrb_d    = mem_wstrb;
    load_funct3_d  = load_funct3;
    eff_addr_d     = eff_addr;
    store_data_d   = store_data;
    wb_rd_d        = wb_rd;
    wb_data_d      = wb_data;
    wb_valid_d     = 1'b0;
    op_done_d      = 1'b0;
    err_misalign_d = 1'b0;
    err_timeout_d  = 1'b0;
`ifdef MRV32_MEM_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready && (in_is_load || in_is_store)) begin
          is_load_d     = ld_c;
          load_funct3_d = in_funct3;
          eff_addr_d    = addr_c;
          store_data_d  = in_rs2;
          wb_rd_d       = in_rd;
          in_ready_d    = 1'b0;
          if (aligned_f(ld_c, in_funct3, addr_c[1:0])) begin
            state_d     = BUSY;
            mem_valid_d = 1'b1;
            mem_ren_d   = ld_c;
            mem_wen_d   = ~ld_c;
            mem_wstrb_d = ld_c ? WSTRB_NONE : wstrb_f(in_funct3[1:0]);
`ifdef MRV32_MEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            state_d        = DONE;
            op_done_d      = 1'b1;
            err_misalign_d = 1'b1;
            wb_valid_d     = ld_c && (in_rd != 5'd0);
            if (ld_c) wb_data_d = 32'd0;
          end
        end
      end
      BUSY: begin
        if (lsu_done) begin
          state_d     = DONE;
          mem_valid_d = 1'b0;
          mem_ren_d   = 1'b0;
          mem_wen_d   = 1'b0;
          mem_wstrb_d = WSTRB_NONE;
          op_done_d   = 1'b1;
          wb_valid_d  = is_load_q && (wb_rd != 5'd0);
          if (is_load_q) wb_data_d = load_data;
        end
`ifdef MRV32_MEM_TIMEOUT_EN
        else if (timeout_c) begin
          state_d       = DONE;
          mem_valid_d   = 1'b0;
          mem_ren_d     = 1'b0;
          mem_wen_d     = 1'b0;
          mem_wstrb_d   = WSTRB_NONE;
          op_done_d     = 1'b1;
          err_timeout_d = 1'b1;
          wb_valid_d    = is_load_q && (wb_rd != 5'd0);
          if (is_load_q) wb_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // All state and outputs registered; reset drops any in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      in_ready     <= 1'b1;
      mem_valid    <= 1'b0;
      mem_ren      <= 1'b0;
      mem_wen      <= 1'b0;
      mem_wstrb    <= WSTRB_NONE;
      load_funct3  <= 3'd0;
      eff_addr     <= 32'd0;
      store_data   <= 32'd0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_valid     <= 1'b0;
      op_done      <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
`ifdef MRV32_MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      in_ready     <= in_ready_d;
      mem_valid    <= mem_valid_d;
      mem_ren      <= mem_ren_d;
      mem_wen      <= mem_wen_d;
      mem_wstrb    <= mem_wstrb_d;
      load_funct3  <= load_funct3_d;
      eff_addr     <= eff_addr_d;
      store_data   <= store_data_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
      wb_valid     <= wb_valid_d;
      op_done      <= op_done_d;
      err_misalign <= err_misalign_d;
      err_timeout  <= err_timeout_d;
`ifdef MRV32_MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mrv32_mem_stage.sv
// Directed bench for mrv32_mem_stage: bench plays the LSU by hand, checks at negedges.
module tb_mrv32_mem_stage;
  import mrv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_rs1 = 32'd0, in_imm = 32'd0, in_rs2 = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        lsu_done = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        in_ready, mem_valid, mem_ren, mem_wen;
  logic [3:0]  mem_wstrb;
  logic [2:0]  load_funct3;
  logic [31:0] eff_addr, store_data, wb_data;
  logic        wb_valid, op_done, err_misalign, err_timeout;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mrv32_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_imm(in_imm), .in_rs2(in_rs2), .in_rd(in_rd),
    .mem_valid(mem_valid), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wstrb(mem_wstrb),
    .load_funct3(load_funct3), .eff_addr(eff_addr), .store_data(store_data),
    .lsu_done(lsu_done), .load_data(load_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_done(op_done), .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; returns at the negedge after the accept edge.
  task automatic send(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                      input logic [31:0] imm, input logic [31:0] rs2, input logic [4:0] rd);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 32'd1);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_rs1 = rs1; in_imm = imm; in_rs2 = rs2; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_rs1 = 32'hBAD0BAD0; in_rs2 = 32'hBAD1BAD1; in_rd = 5'd31;
  endtask

  // Hold BUSY for lat observed cycles, then complete and check DONE and return to IDLE.
  task automatic busy_then_done(input int lat, input logic [31:0] exp_addr, input logic [31:0] ldata,
                                input logic exp_wbv, input logic [4:0] exp_rd, input logic [31:0] exp_wbd);
    for (int i = 0; i < lat; i++) begin
      chk("busy_mem_valid", mem_valid, 32'd1);
      chk("busy_eff_addr", eff_addr, exp_addr);
      chk("busy_in_ready", in_ready, 32'd0);
      chk("busy_op_done", op_done, 32'd0);
      @(negedge clk);
    end
    lsu_done = 1'b1; load_data = ldata;
    @(negedge clk);
    lsu_done = 1'b0; load_data = 32'hDEADBEEF;
    chk("done_mem_valid", mem_valid, 32'd0);
    chk("done_mem_ren", mem_ren, 32'd0);
    chk("done_mem_wen", mem_wen, 32'd0);
    chk("done_mem_wstrb", mem_wstrb, 32'(WSTRB_NONE));
    chk("done_op_done", op_done, 32'd1);
    chk("done_wb_valid", wb_valid, 32'(exp_wbv));
    chk("done_wb_rd", wb_rd, 32'(exp_rd));
    chk("done_wb_data", wb_data, exp_wbd);
    chk("done_err_misalign", err_misalign, 32'd0);
    chk("done_err_timeout", err_timeout, 32'd0);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 32'd1);
    chk("idle_op_done", op_done, 32'd0);
    chk("idle_wb_valid", wb_valid, 32'd0);
  endtask

  // Misaligned/illegal op: DONE immediately after accept, no request, IDLE one cycle later.
  task automatic check_misaligned(input logic exp_wbv, input logic [4:0] exp_rd,
                                  input logic [31:0] exp_wbd, input logic [31:0] exp_addr);
    chk("mis_mem_valid", mem_valid, 32'd0);
    chk("mis_op_done", op_done, 32'd1);
    chk("mis_err_misalign", err_misalign, 32'd1);
    chk("mis_wb_valid", wb_valid, 32'(exp_wbv));
    chk("mis_wb_rd", wb_rd, 32'(exp_rd));
    chk("mis_wb_data", wb_data, exp_wbd);
    chk("mis_eff_addr", eff_addr, exp_addr);
    @(negedge clk);
    chk("mis_idle_in_ready", in_ready, 32'd1);
    chk("mis_idle_mem_valid", mem_valid, 32'd0);
    chk("mis_idle_op_done", op_done, 32'd0);
    chk("mis_idle_err", err_misalign, 32'd0);
  endtask

  initial begin
    int busy_n;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_mem_valid", mem_valid, 32'd0);
    chk("rst_mem_ren", mem_ren, 32'd0);
    chk("rst_mem_wen", mem_wen, 32'd0);
    chk("rst_mem_wstrb", mem_wstrb, 32'(WSTRB_NONE));
    chk("rst_eff_addr", eff_addr, 32'd0);
    chk("rst_store_data", store_data, 32'd0);
    chk("rst_load_funct3", load_funct3, 32'd0);
    chk("rst_wb", {wb_valid, op_done, err_misalign, err_timeout, 3'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;

    // SW 0x100 <- 0xA1B2C3D4
    send(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hA1B2C3D4, 5'd0);
    chk("sw_mem_wen", mem_wen, 32'd1);
    chk("sw_mem_ren", mem_ren, 32'd0);
    chk("sw_wstrb", mem_wstrb, 32'(WSTRB_W));
    chk("sw_store_data", store_data, 32'hA1B2C3D4);
    busy_then_done(3, 32'h100, 32'h12345678, 1'b0, 5'd0, 32'd0);

    // LW x5 <- 0x100
    send(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd5);
    chk("lw_mem_ren", mem_ren, 32'd1);
    chk("lw_mem_wen", mem_wen, 32'd0);
    chk("lw_wstrb", mem_wstrb, 32'(WSTRB_NONE));
    chk("lw_funct3", load_funct3, 32'd2);
    busy_then_done(3, 32'h100, 32'hA1B2C3D4, 1'b1, 5'd5, 32'hA1B2C3D4);

    // SB 0x101 <- 0x80, then LB / LBU
    send(1'b0, 1'b1, 3'b000, 32'h100, 32'h1, 32'h80, 5'd0);
    chk("sb_wstrb", mem_wstrb, 32'(WSTRB_B));
    chk("sb_store_data", store_data, 32'h80);
    busy_then_done(1, 32'h101, 32'h0, 1'b0, 5'd0, 32'hA1B2C3D4);
    send(1'b1, 1'b0, 3'b000, 32'h100, 32'h1, 32'h0, 5'd6);
    busy_then_done(1, 32'h101, 32'hFFFFFF80, 1'b1, 5'd6, 32'hFFFFFF80);
    send(1'b1, 1'b0, 3'b100, 32'h100, 32'h1, 32'h0, 5'd6);
    chk("lbu_funct3", load_funct3, 32'd4);
    busy_then_done(2, 32'h101, 32'h00000080, 1'b1, 5'd6, 32'h00000080);

    // SH / LH with negative immediate: 0x104 + (-2) = 0x102
    send(1'b0, 1'b1, 3'b001, 32'h104, 32'hFFFFFFFE, 32'h8001, 5'd0);
    chk("sh_wstrb", mem_wstrb, 32'(WSTRB_H));
    chk("sh_eff_addr", eff_addr, 32'h102);
    busy_then_done(1, 32'h102, 32'h0, 1'b0, 5'd0, 32'h00000080);
    send(1'b1, 1'b0, 3'b001, 32'h104, 32'hFFFFFFFE, 32'h0, 5'd9);
    busy_then_done(1, 32'h102, 32'hFFFF8001, 1'b1, 5'd9, 32'hFFFF8001);

    // lsu_done while IDLE is ignored
    @(negedge clk); lsu_done = 1'b1; load_data = 32'h55555555;
    @(negedge clk); lsu_done = 1'b0;
    chk("stray_done_op_done", op_done, 32'd0);
    chk("stray_done_wb_data", wb_data, 32'hFFFF8001);
    chk("stray_done_in_ready", in_ready, 32'd1);

    // Misaligned LW at 0x102, illegal load funct3, illegal store funct3
    send(1'b1, 1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd7);
    check_misaligned(1'b1, 5'd7, 32'd0, 32'h102);
    send(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd8);
    check_misaligned(1'b1, 5'd8, 32'd0, 32'h100);
    send(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h77, 5'd0);
    check_misaligned(1'b0, 5'd0, 32'd0, 32'h100);

    // in_valid with neither flag set is ignored
    @(negedge clk); in_valid = 1'b1; in_rs1 = 32'h300;
    @(negedge clk); in_valid = 1'b0;
    chk("noop_in_ready", in_ready, 32'd1);
    chk("noop_mem_valid", mem_valid, 32'd0);
    chk("noop_eff_addr", eff_addr, 32'h100);

    // Both flags: load wins
    send(1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 32'h99, 5'd4);
    chk("both_mem_ren", mem_ren, 32'd1);
    chk("both_mem_wen", mem_wen, 32'd0);
    busy_then_done(1, 32'h200, 32'hCAFEF00D, 1'b1, 5'd4, 32'hCAFEF00D);

    // LW to x0: retires without writeback pulse
    send(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd0);
    busy_then_done(1, 32'h100, 32'h11111111, 1'b0, 5'd0, 32'h11111111);

    // Address wraps modulo 2^32
    send(1'b1, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd2);
    busy_then_done(1, 32'h4, 32'h44, 1'b1, 5'd2, 32'h44);

    // Reset during BUSY drops the request asynchronously
    send(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd3);
    chk("rstbusy_mem_valid_pre", mem_valid, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy_mem_valid", mem_valid, 32'd0);
    chk("rstbusy_mem_ren", mem_ren, 32'd0);
    chk("rstbusy_in_ready", in_ready, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rstbusy_op_done", op_done, 32'd0);
    chk("rstbusy_wb_valid", wb_valid, 32'd0);
    chk("rstbusy_wb_data", wb_data, 32'd0);

    // Preload wb_data so a zeroed abort result is visible
    send(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd3);
    busy_then_done(1, 32'h100, 32'h5A5A5A5A, 1'b1, 5'd3, 32'h5A5A5A5A);

    // Hung LSU
    send(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd3);
    busy_n = 0;
`ifdef MRV32_MEM_TIMEOUT_EN
    while (mem_valid === 1'b1 && busy_n < 40) begin
      busy_n++;
      @(negedge clk);
    end
    chk("to_busy_cycles", 32'(busy_n), 32'd16);
    chk("to_err_timeout", err_timeout, 32'd1);
    chk("to_op_done", op_done, 32'd1);
    chk("to_wb_valid", wb_valid, 32'd1);
    chk("to_wb_data", wb_data, 32'd0);
    @(negedge clk);
    chk("to_idle_in_ready", in_ready, 32'd1);
`else
    while (mem_valid === 1'b1 && busy_n < 40) begin
      busy_n++;
      @(negedge clk);
    end
    chk("noto_busy_cycles", 32'(busy_n), 32'd40);
    chk("noto_err_timeout", err_timeout, 32'd0);
    busy_then_done(1, 32'h100, 32'h0BADF00D, 1'b1, 5'd3, 32'h0BADF00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mrv32_mem_stage.md
# mrv32_mem_stage

Memory-stage controller sitting directly upstream of `mrv32_lsu`. It accepts one decoded load/store per transaction from execute, computes the effective address, and drives the LSU request bus, holding it stable until `lsu_done`. It then returns load results to register writeback and releases the pipeline. Misaligned accesses are caught locally and never issued to the LSU.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16, BUSY cycles before abort (only with `MRV32_MEM_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  execute presents an op.
- `in_ready`  out  1  stage can accept; high only in IDLE.
- `in_is_load`  in  1  op is a load.
- `in_is_store`  in  1  op is a store.
- `in_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `in_rs1`  in  32  base register value.
- `in_imm`  in  32  sign-extended immediate.
- `in_rs2`  in  32  store data.
- `in_rd`  in  5  load destination.
- `mem_valid`, `mem_ren`, `mem_wen`  out  1 each  LSU request.
- `mem_wstrb`  out  4  `WSTRB_B/H/W/NONE` from `mrv32_pkg`.
- `load_funct3`  out  3  forwarded load funct3.
- `eff_addr`  out  32  `in_rs1 + in_imm`.
- `store_data`  out  32  unshifted `in_rs2`.
- `lsu_done`  in  1  LSU completion.
- `load_data`  in  32  extended load result, valid while `lsu_done`=1.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_rd`  out  5  writeback register.
- `wb_data`  out  32  writeback value.
- `op_done`  out  1  one-cycle pulse on every retired op (load or store).
- `err_misalign`  out  1  pulses with `op_done` for misaligned op.
- `err_timeout`  out  1  pulses with `op_done` on timeout abort.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. Accept on `in_valid & in_ready & (in_is_load | in_is_store)`. Latch rd, funct3, rs2; compute `eff_addr` (32-bit add, wraps modulo 2^32). If both flags set, load wins. `in_valid` with neither flag: ignored, stay IDLE.
- Alignment: H needs `addr[0]==0`; W needs `addr[1:0]==0`; B always aligned. funct3 011/110/111 (loads) or ≥011 (stores) treated as misaligned/illegal.
- Aligned -> BUSY; misaligned -> DONE directly with `err_misalign` latched, no LSU request.
- BUSY: `mem_valid`=1, `mem_ren`=load, `mem_wen`=store, `mem_wstrb`=B/H/W by funct3[1:0] for stores, `WSTRB_NONE` for loads; all request outputs constant. When `lsu_done`=1 at a rising edge: register `load_data` into `wb_data` (loads), go DONE.
- DONE (one cycle): all `mem_*` deasserted, `mem_wstrb`=`WSTRB_NONE`; `op_done`=1; `wb_valid`=1 iff load and `wb_rd`!=0; misaligned/timeout loads write `wb_data`=0. Next state IDLE.
- `lsu_done` seen outside BUSY is ignored.
- Reset mid-op: immediate return to IDLE, request dropped asynchronously; no writeback.

## Timing
- Reset values: `in_ready`=1; `mem_valid`/`mem_ren`/`mem_wen`=0; `mem_wstrb`=`WSTRB_NONE`; `load_funct3`, `eff_addr`, `store_data`, `wb_rd`, `wb_data`=0; `wb_valid`, `op_done`, `err_*`=0.
- All outputs registered.
- Accept edge E0 -> `mem_valid` high from E0.
- `lsu_done` sampled high at edge En -> DONE cycle after En (`mem_valid` low, `wb_valid` high) -> IDLE after En+1.
- Misaligned: accept E0 -> DONE cycle E0..E1 -> IDLE at E1.
- Back-to-back issue: at best every (LSU latency + 2) cycles.

## Configuration
- `MRV32_MEM_TIMEOUT_EN` defined: counter cleared on BUSY entry, increments each BUSY cycle. When it reaches `TIMEOUT_CYCLES` without `lsu_done`, request is dropped and state goes to DONE with `err_timeout`=1 and load `wb_data`=0.
- Undefined: no counter, BUSY waits indefinitely, `err_timeout` tied 0.

## Test plan
- SW rs1=0x100, imm=0, rs2=0xA1B2C3D4, then LW rd=5 -> `wb_valid` with rd=5, data=0xA1B2C3D4; `mem_valid` stable through BUSY.
- SB rs1=0x100, imm=1, data 0x80; LB then LBU at 0x101 -> 0xFFFFFF80, then 0x00000080.
- LH rs1=0x104, imm=-2 (0x102) after SH 0x8001 -> 0xFFFF8001; eff_addr=0x102 confirms sign-extended imm add.
- LW at 0x102 -> no `mem_valid` ever, `err_misalign`+`wb_valid` with data 0, back to IDLE within 2 cycles.
- LW rd=0 -> `op_done` pulses, `wb_valid` stays 0; reset asserted during BUSY -> `mem_valid` drops immediately, no `op_done`.
- With `MRV32_MEM_TIMEOUT_EN`, LSU `lsu_done` forced 0 -> after 16 BUSY cycles `err_timeout`=1, `wb_data`=0.
